// File: rtl/mem_pkg.sv
// Shared types for the line memory responder: FSM states and the line type.
// Latency: n/a (types only).
// Backpressure: n/a (types only).
package mem_pkg;

  // Default line size in bytes. line_t is the line type at this default size.
  localparam int unsigned LINE_BYTES = 64;

  typedef logic [LINE_BYTES*8-1:0] line_t;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WAIT    = 2'd1,
    RESPOND = 2'd2
  } state_e;

endpackage

// File: rtl/line_mem_responder_if.sv
// Request/response bundle between a cache lower port and the line responder.
// Latency: n/a (wires only).
// Backpressure: req uses valid/ready, resp uses valid/ready.
// Ports: master = cache side (drives req_*, resp_ready_in); slave = responder.
interface line_mem_responder_if
  import mem_pkg::*;
#(
  parameter int B         = LINE_BYTES,
  parameter int ADDR_BITS = 64
);
  logic                 req_valid_in;
  logic                 req_ready_out;
  logic [ADDR_BITS-1:0] req_addr_in;
  logic [B*8-1:0]       req_value_in;
  logic                 req_we_in;
  logic                 resp_valid_out;
  logic                 resp_ready_in;
  logic [ADDR_BITS-1:0] resp_addr_out;
  logic [B*8-1:0]       resp_value_out;

  modport master (
    output req_valid_in, req_addr_in, req_value_in, req_we_in, resp_ready_in,
    input  req_ready_out, resp_valid_out, resp_addr_out, resp_value_out
  );

  modport slave (
    input  req_valid_in, req_addr_in, req_value_in, req_we_in, resp_ready_in,
    output req_ready_out, resp_valid_out, resp_addr_out, resp_value_out
  );
endinterface

// File: rtl/line_store.sv
// Line storage array, DEPTH lines of W bits, contents not reset.
// Latency: write on rising edge, read combinational.
// Backpressure: none, always accepts a write.
// Ports: clk_i, we_i/waddr_i/wdata_i write port, raddr_i/rdata_o read port.
module line_store #(
  parameter int DEPTH = 64,
  parameter int W     = 512
) (
  input  logic                     clk_i,
  input  logic                     we_i,
  input  logic [$clog2(DEPTH)-1:0] waddr_i,
  input  logic [W-1:0]             wdata_i,
  input  logic [$clog2(DEPTH)-1:0] raddr_i,
  output logic [W-1:0]             rdata_o
);
  logic [W-1:0] mem_q [DEPTH];

  always_ff @(posedge clk_i) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
  end

  assign rdata_o = mem_q[raddr_i];
endmodule

// File: rtl/line_mem_responder.sv
// Fixed-latency line memory behind a cache: reads return a fill, writes are silent.
// Latency: response/ready return exactly LATENCY cycles after the accept edge.
// Backpressure: one request outstanding; ready only in IDLE; fill held until resp_ready_in.
// Ports: clk_in, rst_N_in (async active-low), bus (slave side of line_mem_responder_if).
module line_mem_responder
  import mem_pkg::*;
#(
  parameter int B         = LINE_BYTES,
  parameter int ADDR_BITS = 64,
  parameter int DEPTH     = 64,
  parameter int LATENCY   = 4
) (
  input  logic                 clk_in,
  input  logic                 rst_N_in,
  line_mem_responder_if.slave  bus
);
  localparam int OFF_W = $clog2(B);
  localparam int IDX_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(LATENCY + 1);
  localparam logic [CNT_W-1:0]     CNT_LOAD = CNT_W'(LATENCY - 1);
  localparam logic [ADDR_BITS-1:0] OFF_MASK = ADDR_BITS'((64'd1 << OFF_W) - 64'd1);

  state_e                 state_q;
  logic [CNT_W-1:0]       cnt_q;
  logic [ADDR_BITS-1:0]   addr_q;
  logic                   we_q;
  logic                   req_ready_q;
  logic                   resp_valid_q;
  logic [ADDR_BITS-1:0]   resp_addr_q;
  logic [B*8-1:0]         resp_value_q;
  logic [B*8-1:0]         rd_line;
  logic                   accept;

  // req_ready_q is only ever 1 in IDLE, so it alone qualifies the handshake.
  assign accept = bus.req_valid_in & req_ready_q;

  // Write data goes straight into storage on the accept edge; the store
  // itself is the latch for it, so no separate data register is kept.
  line_store #(
    .DEPTH (DEPTH),
    .W     (B*8)
  ) u_store (
    .clk_i   (clk_in),
    .we_i    (accept & bus.req_we_in),
    .waddr_i (bus.req_addr_in[OFF_W +: IDX_W]),
    .wdata_i (bus.req_value_in),
    .raddr_i (addr_q[OFF_W +: IDX_W]),
    .rdata_o (rd_line)
  );

  always_ff @(posedge clk_in or negedge rst_N_in) begin
    if (!rst_N_in) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      addr_q       <= '0;
      we_q         <= 1'b0;
      req_ready_q  <= 1'b0;
      resp_valid_q <= 1'b0;
      resp_addr_q  <= '0;
      resp_value_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (accept) begin
            state_q     <= WAIT;
            cnt_q       <= CNT_LOAD;
            addr_q      <= bus.req_addr_in;
            we_q        <= bus.req_we_in;
            req_ready_q <= 1'b0;
          end else begin
            // Also covers the first edge after reset release.
            req_ready_q <= 1'b1;
          end
        end
        WAIT: begin
          if (cnt_q == '0) begin
            if (we_q) begin
              state_q     <= IDLE;
              req_ready_q <= 1'b1;
            end else begin
              // Reading here (not at accept) lets the fill see every
              // write committed before this point.
              state_q      <= RESPOND;
              resp_valid_q <= 1'b1;
              resp_addr_q  <= addr_q & ~OFF_MASK;
              resp_value_q <= rd_line;
            end
          end else begin
            cnt_q <= cnt_q - CNT_W'(1);
          end
        end
        RESPOND: begin
          if (bus.resp_ready_in) begin
            state_q      <= IDLE;
            req_ready_q  <= 1'b1;
            resp_valid_q <= 1'b0;
            resp_addr_q  <= '0;
            resp_value_q <= '0;
          end
        end
        default: begin
          state_q     <= IDLE;
          req_ready_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.req_ready_out  = req_ready_q;
  assign bus.resp_valid_out = resp_valid_q;
  assign bus.resp_addr_out  = resp_addr_q;
  assign bus.resp_value_out = resp_value_q;
endmodule

// File: tb/tb_line_mem_responder.sv
// Bench for line_mem_responder: directed scenarios followed by random traffic
// checked against a line-array reference model.
module tb_line_mem_responder;
  import mem_pkg::*;

  localparam int LAT = 4;

  logic clk;
  logic rst_n;
  int   n_assert = 0;
  int   n_fail   = 0;

  line_t model [64];
  bit    written [64];

  line_mem_responder_if #(.B(64), .ADDR_BITS(64)) bus ();

  line_mem_responder #(
    .B         (64),
    .ADDR_BITS (64),
    .DEPTH     (64),
    .LATENCY   (LAT)
  ) dut (
    .clk_in   (clk),
    .rst_N_in (rst_n),
    .bus      (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic line_t rand_line();
    line_t l;
    for (int i = 0; i < 16; i++) l[i*32 +: 32] = $urandom;
    return l;
  endfunction

  // Line index: byte address divided by line size, wrapped modulo DEPTH.
  function automatic int midx(input logic [63:0] a);
    return int'((a / 64) % 64);
  endfunction

  // All tasks start and end at a falling edge.
  task automatic wait_ready();
    int t = 0;
    while (bus.req_ready_out !== 1'b1 && t < 20) begin
      @(negedge clk);
      t++;
    end
    chk("ready_before_req", bus.req_ready_out, 1'b1);
  endtask

  task automatic present(input logic we, input logic [63:0] a, input line_t d);
    wait_ready();
    bus.req_valid_in = 1'b1;
    bus.req_we_in    = we;
    bus.req_addr_in  = a;
    bus.req_value_in = d;
    @(posedge clk);
    @(negedge clk);
    // Scramble request inputs: the responder must have latched them.
    bus.req_valid_in = 1'b0;
    bus.req_addr_in  = {$urandom, $urandom};
    bus.req_value_in = rand_line();
    bus.req_we_in    = 1'($urandom);
  endtask

  task automatic run_write(input logic [63:0] a, input line_t d);
    present(1'b1, a, d);
    model[midx(a)]   = d;
    written[midx(a)] = 1'b1;
    for (int n = 0; n < LAT; n++) begin
      chk("wr_ready_low", bus.req_ready_out, 1'b0);
      chk("wr_no_resp", bus.resp_valid_out, 1'b0);
      @(negedge clk);
    end
    chk("wr_ready_back", bus.req_ready_out, 1'b1);
    chk("wr_no_resp_end", bus.resp_valid_out, 1'b0);
  endtask

  task automatic run_read(input logic [63:0] a, input int hold, input bit keep);
    line_t       exp_d;
    logic [63:0] exp_a;
    present(1'b0, a, '0);
    exp_d = model[midx(a)];
    exp_a = a - (a % 64);
    for (int n = 0; n < LAT; n++) begin
      if (keep) begin
        bus.req_valid_in = 1'b1;
        bus.req_we_in    = 1'b0;
        bus.req_addr_in  = {$urandom, $urandom};
      end
      chk("rd_wait_valid", bus.resp_valid_out, 1'b0);
      chk("rd_wait_ready", bus.req_ready_out, 1'b0);
      chk("rd_wait_addr", bus.resp_addr_out, 64'h0);
      chk("rd_wait_data", bus.resp_value_out, 512'h0);
      @(negedge clk);
    end
    for (int h = 0; h < hold; h++) begin
      if (keep) bus.req_addr_in = {$urandom, $urandom};
      chk("rd_resp_valid", bus.resp_valid_out, 1'b1);
      chk("rd_resp_addr", bus.resp_addr_out, exp_a);
      chk("rd_resp_data", bus.resp_value_out, exp_d);
      chk("rd_resp_ready", bus.req_ready_out, 1'b0);
      if (h == hold - 1) begin
        bus.resp_ready_in = 1'b1;
        bus.req_valid_in  = 1'b0;
      end
      @(negedge clk);
    end
    bus.resp_ready_in = 1'b0;
    chk("rd_done_valid", bus.resp_valid_out, 1'b0);
    chk("rd_done_addr", bus.resp_addr_out, 64'h0);
    chk("rd_done_data", bus.resp_value_out, 512'h0);
    chk("rd_done_ready", bus.req_ready_out, 1'b1);
  endtask

  task automatic reset_pulse();
    rst_n = 1'b0;
    #1;
    chk("rst_async_valid", bus.resp_valid_out, 1'b0);
    chk("rst_async_ready", bus.req_ready_out, 1'b0);
    chk("rst_async_addr", bus.resp_addr_out, 64'h0);
    chk("rst_async_data", bus.resp_value_out, 512'h0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("rst_rel_ready_low", bus.req_ready_out, 1'b0);
    @(negedge clk);
    chk("rst_rel_ready_up", bus.req_ready_out, 1'b1);
    for (int n = 0; n < LAT + 2; n++) begin
      chk("rst_no_resp", bus.resp_valid_out, 1'b0);
      @(negedge clk);
    end
  endtask

  initial begin
    line_t       x;
    line_t       y;
    logic [63:0] a;
    logic [63:0] hi;
    logic        we;

    rst_n             = 1'b0;
    bus.req_valid_in  = 1'b0;
    bus.req_we_in     = 1'b0;
    bus.req_addr_in   = '0;
    bus.req_value_in  = '0;
    bus.resp_ready_in = 1'b0;
    #1;
    chk("reset_ready", bus.req_ready_out, 1'b0);
    chk("reset_valid", bus.resp_valid_out, 1'b0);
    chk("reset_addr", bus.resp_addr_out, 64'h0);
    chk("reset_data", bus.resp_value_out, 512'h0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("release_ready_low", bus.req_ready_out, 1'b0);
    @(negedge clk);
    chk("release_ready_up", bus.req_ready_out, 1'b1);

    // Write then read back from inside the same line.
    run_write(64'h1000, {64{8'hA5}});
    run_read(64'h1024, 1, 1'b0);

    // Fill held under backpressure.
    run_read(64'h1000, 7, 1'b0);

    // Aliasing: 0x1040 maps onto the same line as 0x0040.
    x = rand_line();
    y = rand_line();
    run_write(64'h0040, x);
    run_write(64'h1040, y);
    run_read(64'h0040, 1, 1'b0);

    // Valid held high with wandering address through WAIT/RESPOND.
    run_read(64'h1000, 2, 1'b1);

    // Reset two cycles into a read; committed writes survive.
    present(1'b0, 64'h1000, '0);
    @(negedge clk);
    @(negedge clk);
    reset_pulse();
    run_read(64'h1000, 1, 1'b0);

    // Reset while a fill is being presented.
    present(1'b0, 64'h0040, '0);
    repeat (LAT) @(negedge clk);
    chk("respond_before_rst", bus.resp_valid_out, 1'b1);
    reset_pulse();
    run_read(64'h0040, 1, 1'b0);

    // Random traffic against the model.
    for (int i = 0; i < 60; i++) begin
      hi = {$urandom, $urandom} >> 12;
      a  = (hi << 12) + 64'($urandom_range(0, 15)) * 64 + 64'($urandom_range(0, 63));
      we = 1'($urandom);
      if (!written[midx(a)]) we = 1'b1;
      if (we) run_write(a, rand_line());
      else    run_read(a, int'($urandom_range(1, 3)), 1'($urandom));
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
